// File: rtl/mux_nto1_rr.sv
// N-channel valid/ready data mux with one registered output stage.
// The source is chosen by an external select or by a fair round-robin arbiter.
module mux_nto1_rr #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rr_en,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    input  logic                    out_ready
);

    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_chan_q, out_chan_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 load_en;
    logic                 grant_vld;
    logic [SEL_W-1:0]     grant_idx;
    logic [SEL_W:0]       search_sum;
    logic [SEL_W-1:0]     search_idx;
    logic                 fire;
    logic [WIDTH-1:0]     grant_data;

    assign load_en = !out_valid_q || out_ready;

    // Arbitration: fixed select, or first valid channel scanning upward from rr_ptr with wrap.
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_sum = '0;
        search_idx = '0;
        if (rr_en) begin
            for (int k = 0; k < N_CH; k++) begin
                search_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
                if (search_sum >= N_CH_W) begin
                    search_sum = search_sum - N_CH_W;
                end
                search_idx = search_sum[SEL_W-1:0];
                if (!grant_vld && in_valid[search_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = search_idx;
                end
            end
        end else if (({1'b0, sel} < N_CH_W) && in_valid[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
        end
    end

    assign fire = grant_vld && load_en;

    // NOTE: in_ready is forced low while rst_n is asserted, even though the register is free.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = fire && rst_n;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            if (rr_en) begin
                rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: a cycle model plus directed and random stimulus.
// A 5-channel instance covers the out-of-range select case.
module tb_mux_nto1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rr_en;
    logic [SW-1:0]     sel;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_chan;
    logic              out_ready;

    logic              rr_en5;
    logic [2:0]        sel5;
    logic [4:0]        in_valid5;
    logic [5*W-1:0]    in_data5;
    logic [4:0]        in_ready5;
    logic              out_valid5;
    logic [W-1:0]      out_data5;
    logic [2:0]        out_chan5;
    logic              out_ready5;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux_nto1_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    mux_nto1_rr #(.N_CH(5), .WIDTH(W)) dut5 (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en5), .sel(sel5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_chan(out_chan5),
        .out_ready(out_ready5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the output word, its source and the arbiter pointer.
    logic       m_valid;
    logic [W-1:0] m_data;
    int         m_chan;
    int         m_ptr;
    int         exp_g;
    logic [N-1:0] exp_ready;

    function automatic int exp_grant(input logic rr, input logic [SW-1:0] s,
                                     input logic [N-1:0] v, input int ptr, input logic ld);
        if (!ld) return -1;
        if (!rr) return (int'(s) < N && v[s]) ? int'(s) : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always_comb begin
        exp_g     = exp_grant(rr_en, sel, in_valid, m_ptr, !m_valid || out_ready);
        exp_ready = '0;
        if (rst_n && exp_g >= 0) exp_ready = N'(1 << exp_g);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
            m_ptr   <= 0;
        end else if (exp_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[exp_g*W +: W];
            m_chan  <= exp_g;
            if (rr_en) m_ptr <= (exp_g + 1) % N;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_chan",  32'(out_chan),  32'(m_chan));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rr_en      = 1'b1;
        sel        = '0;
        in_valid   = 4'b1111;
        in_data    = 32'h13121110;
        out_ready  = 1'b1;
        rr_en5     = 1'b0;
        sel5       = '0;
        in_valid5  = '0;
        in_data5   = '0;
        out_ready5 = 1'b1;

        // Reset with every channel valid, then release.
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'b0001);

        // Round-robin over four busy channels: 0,1,2,3,0,1,2,3 with no bubbles.
        tick();
        check("rr_first_chan",  32'(out_chan),  32'd0);
        check("rr_first_data",  32'(out_data),  32'h10);
        check("rr_first_valid", 32'(out_valid), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("rr_seq_chan",  32'(out_chan),  32'(i % 4));
            check("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Fixed mode, sel=2.
        rr_en = 1'b0;
        sel   = 2'd2;
        in_data[23:16] = 8'hA5;
        #1;
        check("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("fix_data", 32'(out_data), 32'hA5);
        check("fix_chan", 32'(out_chan), 32'd2);

        // Backpressure; mode and select changes while stalled must not matter.
        rr_en = 1'b1;
        in_data[23:16] = 8'h12;
        out_ready = 1'b0;
        #1;
        check("stall_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rr_en = i[0];
            sel   = SW'(i);
            tick();
            check("stall_data",     32'(out_data),  32'hA5);
            check("stall_chan",     32'(out_chan),  32'd2);
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready),  32'd0);
        end
        rr_en     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'b0001);
        tick();
        check("unstall_chan", 32'(out_chan), 32'd0);
        check("unstall_data", 32'(out_data), 32'h10);

        // Sparse round-robin from pointer 1: grant 3, then wrap to 0.
        in_valid = 4'b1001;
        #1;
        check("sparse_in_ready3", 32'(in_ready), 32'b1000);
        tick();
        check("sparse_chan3",     32'(out_chan), 32'd3);
        check("sparse_data3",     32'(out_data), 32'h13);
        check("sparse_in_ready0", 32'(in_ready), 32'b0001);
        tick();
        check("sparse_chan0", 32'(out_chan), 32'd0);
        in_valid = '0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_chan",  32'(out_chan),  32'd0);
        check("drain_data",  32'(out_data),  32'h10);

        // Five channels: sel=5 is out of range, sel=4 is the last legal channel.
        in_valid5 = 5'h1F;
        in_data5  = 40'h44_33_22_11_00;
        sel5      = 3'd5;
        #1;
        check("n5_bad_sel_ready", 32'(in_ready5), 32'd0);
        tick();
        check("n5_bad_sel_ready2", 32'(in_ready5),  32'd0);
        check("n5_bad_sel_valid",  32'(out_valid5), 32'd0);
        sel5 = 3'd4;
        #1;
        check("n5_sel4_ready", 32'(in_ready5), 32'b10000);
        tick();
        check("n5_sel4_chan", 32'(out_chan5),  32'd4);
        check("n5_sel4_data", 32'(out_data5),  32'h44);
        sel5 = 3'd5;
        tick();
        check("n5_drain_valid", 32'(out_valid5), 32'd0);

        // Random traffic checked by the model on every cycle.
        for (int i = 0; i < 400; i++) begin
            rr_en     = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset while a word is pending.
        rr_en     = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h3C2B1A09;
        out_ready = 1'b1;
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",    32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        check("post_rst_chan", 32'(out_chan), 32'd0);
        check("post_rst_data", 32'(out_data), 32'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
